// File: rtl/dccm_arb_if.sv
// dccm_arb_if: LSU/DMA request-response bundle plus the DCCM command/read-data port.
interface dccm_arb_if;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dccm_wr_en, dccm_rd_en;
  logic [31:0] dccm_wr_addr, dccm_rd_addr, dccm_wr_data, dccm_rd_data;
  modport slave (
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  dccm_rd_data,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output dccm_wr_en, dccm_rd_en, dccm_wr_addr, dccm_rd_addr, dccm_wr_data
  );
  modport master (
    output lsu_req, lsu_we, lsu_addr, lsu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output dccm_rd_data,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  dccm_wr_en, dccm_rd_en, dccm_wr_addr, dccm_rd_addr, dccm_wr_data
  );
endinterface

// File: rtl/dccm_arb.sv
// dccm_arb: shares the single DCCM port between LSU and DMA; LSU has priority,
// a starvation counter forces a DMA grant after STARVE_MAX denied cycles.
module dccm_arb #(
  parameter int STARVE_MAX = 4
) (
  input logic       clk,
  input logic       rst_n,
  dccm_arb_if.slave b
);
  typedef enum logic {LSU_PRI, DMA_PRI} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_starve_cnt, w_starve_nxt;
  logic        r_rd_pend, r_rd_owner;
  logic        w_dma_win, w_lsu_win, w_any, w_we;
  logic [31:0] w_addr, w_wdata;
  // grants are combinational, so they are gated by rst_n to stay low while reset is held
  assign w_dma_win = rst_n & b.dma_req & (~b.lsu_req | (r_state == DMA_PRI));
  assign w_lsu_win = rst_n & b.lsu_req & ~w_dma_win;
  assign w_any     = w_lsu_win | w_dma_win;
  assign w_we      = w_dma_win ? b.dma_we : b.lsu_we;
  assign w_addr    = w_dma_win ? b.dma_addr : b.lsu_addr;
  assign w_wdata   = w_dma_win ? b.dma_wdata : b.lsu_wdata;
  assign b.lsu_gnt      = w_lsu_win;
  assign b.dma_gnt      = w_dma_win;
  assign b.dccm_wr_en   = w_any & w_we;
  assign b.dccm_rd_en   = w_any & ~w_we;
  assign b.dccm_wr_addr = b.dccm_wr_en ? w_addr : '0;
  assign b.dccm_wr_data = b.dccm_wr_en ? w_wdata : '0;
  assign b.dccm_rd_addr = b.dccm_rd_en ? w_addr : '0;
  assign b.lsu_rvalid   = r_rd_pend & ~r_rd_owner;
  assign b.dma_rvalid   = r_rd_pend & r_rd_owner;
  assign b.lsu_rdata    = b.lsu_rvalid ? b.dccm_rd_data : '0;
  assign b.dma_rdata    = b.dma_rvalid ? b.dccm_rd_data : '0;
  always_comb begin
    w_starve_nxt = (b.dma_req & ~w_dma_win) ? r_starve_cnt + 8'(r_starve_cnt != 8'hff) : '0;
    w_next = (r_state == LSU_PRI)
           ? ((b.dma_req & ~w_dma_win & (r_starve_cnt == 8'(STARVE_MAX - 1))) ? DMA_PRI : LSU_PRI)
           : ((w_dma_win | ~b.dma_req) ? LSU_PRI : DMA_PRI);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= LSU_PRI;
      r_starve_cnt <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_starve_cnt <= w_starve_nxt;
      r_rd_pend    <= b.dccm_rd_en;
      r_rd_owner   <= w_dma_win;
    end
endmodule
